// File: rtl/gppcu_fpu_arbiter.sv
// gppcu_fpu_arbiter
//   Shares one multi-cycle FPU (start/done protocol) among N_THR threads.
//   It grants requests round-robin and captures the winner's opcode and
//   operands. It then pulses START, waits for the FPU to finish, and returns
//   the result with a one-cycle DONE pulse to the owning thread. A watchdog
//   forces completion with a zero result if the FPU never answers.
//
// Ports
//   iACLK / inRST             clock (posedge) / async active-low reset
//   iREQ[N_THR]               per-thread request, held until oDONE[i]
//   iOPC[3*N_THR]             per-thread opcode, slice [3i+:3]
//   iDA/iDB[32*N_THR]         per-thread operands, slice [32i+:32]
//   oBUSY[N_THR]              stall, iREQ & ~oDONE (combinational)
//   oDONE[N_THR]              one-hot completion pulse
//   oRESULT[32]               result, valid while any oDONE bit is high
//   oTMO                      watchdog-fired flag, pulses with oDONE
//   oFPU_START                one-cycle start pulse to the FPU
//   oFPU_N/oFPU_DA/oFPU_DB    registered opcode / operands to the FPU
//   iFPU_DONE / iFPU_RESULT   FPU completion strobe / result
module gppcu_fpu_arbiter #(
    parameter int unsigned N_THR   = 4,
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic                iACLK,
    input  logic                inRST,
    input  logic [N_THR-1:0]    iREQ,
    input  logic [3*N_THR-1:0]  iOPC,
    input  logic [32*N_THR-1:0] iDA,
    input  logic [32*N_THR-1:0] iDB,
    output logic [N_THR-1:0]    oBUSY,
    output logic [N_THR-1:0]    oDONE,
    output logic [31:0]         oRESULT,
    output logic                oTMO,
    output logic                oFPU_START,
    output logic [2:0]          oFPU_N,
    output logic [31:0]         oFPU_DA,
    output logic [31:0]         oFPU_DB,
    input  logic                iFPU_DONE,
    input  logic [31:0]         iFPU_RESULT
);

    localparam int unsigned PW = (N_THR > 1) ? $clog2(N_THR) : 1;
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [TW-1:0]    tmo_cnt;
    logic             tmo_flag;

    logic             any_req;
    logic             found;
    logic [PW-1:0]    win;
    logic [PW-1:0]    win_nx;
    logic [PW-1:0]    scan_idx;
    int unsigned      scan_sum;
    logic [2:0]       sel_opc;
    logic [31:0]      sel_da;
    logic [31:0]      sel_db;

    // Round-robin winner: first set request at rr_ptr, rr_ptr+1, ... mod N_THR.
    always_comb begin
        any_req  = |iREQ;
        found    = 1'b0;
        win      = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_THR; k++) begin
            scan_sum = 32'(rr_ptr) + k;
            if (scan_sum >= N_THR) begin
                scan_sum = scan_sum - N_THR;
            end
            scan_idx = PW'(scan_sum);
            if (!found && iREQ[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
        win_nx = (win == PW'(N_THR - 1)) ? '0 : win + PW'(1);
    end

    // Operand mux written with constant slices so every index stays in range.
    always_comb begin
        sel_opc = '0;
        sel_da  = '0;
        sel_db  = '0;
        for (int unsigned k = 0; k < N_THR; k++) begin
            if (win == PW'(k)) begin
                sel_opc = iOPC[3*k +: 3];
                sel_da  = iDA[32*k +: 32];
                sel_db  = iDB[32*k +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (iFPU_DONE || (tmo_cnt == TMO_LAST)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        oDONE      = '0;
        oTMO       = 1'b0;
        oFPU_START = (state == S_ISSUE);
        if (state == S_DONE) begin
            oDONE[owner] = 1'b1;
            oTMO         = tmo_flag;
        end
    end

    assign oBUSY = iREQ & ~oDONE;

    // Datapath: grant capture, watchdog, result capture
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            rr_ptr   <= '0;
            owner    <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
            oRESULT  <= '0;
            oFPU_N   <= '0;
            oFPU_DA  <= '0;
            oFPU_DB  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner   <= win;
                        rr_ptr  <= win_nx;
                        oFPU_N  <= sel_opc;
                        oFPU_DA <= sel_da;
                        oFPU_DB <= sel_db;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (iFPU_DONE) begin
                        oRESULT <= iFPU_RESULT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        oRESULT  <= '0;
                        tmo_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    tmo_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gppcu_fpu_arbiter.sv
module tb_gppcu_fpu_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic          iACLK = 1'b0;
    logic          inRST;
    logic [3:0]    iREQ;
    logic [11:0]   iOPC;
    logic [127:0]  iDA;
    logic [127:0]  iDB;
    logic [3:0]    oBUSY;
    logic [3:0]    oDONE;
    logic [31:0]   oRESULT;
    logic          oTMO;
    logic          oFPU_START;
    logic [2:0]    oFPU_N;
    logic [31:0]   oFPU_DA;
    logic [31:0]   oFPU_DB;
    logic          iFPU_DONE;
    logic [31:0]   iFPU_RESULT;

    int tests = 0;
    int fails = 0;
    int rr_m  = 0;   // model round-robin pointer

    gppcu_fpu_arbiter #(.N_THR(N), .TMO_CYC(TMO)) dut (
        .iACLK(iACLK), .inRST(inRST), .iREQ(iREQ), .iOPC(iOPC), .iDA(iDA), .iDB(iDB),
        .oBUSY(oBUSY), .oDONE(oDONE), .oRESULT(oRESULT), .oTMO(oTMO),
        .oFPU_START(oFPU_START), .oFPU_N(oFPU_N), .oFPU_DA(oFPU_DA), .oFPU_DB(oFPU_DB),
        .iFPU_DONE(iFPU_DONE), .iFPU_RESULT(iFPU_RESULT)
    );

    always #5 iACLK = ~iACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge iACLK);
    endtask

    // Reference FPU function (arbitrary but deterministic)
    function automatic logic [31:0] fpu_f(input logic [2:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + 32'(opc);
    endfunction

    // Round-robin choice: first requester at ptr, ptr+1, ... (mod N)
    function automatic int pick(input logic [3:0] m, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic scramble();
        iOPC = 12'($urandom);
        iDA  = {$urandom, $urandom, $urandom, $urandom};
        iDB  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        inRST = 1'b0;
        iFPU_DONE = 1'b0;
        iREQ = 4'($urandom);
        #1;
        chk("rst_done",  32'(oDONE), 32'h0);
        chk("rst_start", 32'(oFPU_START), 32'h0);
        chk("rst_busy",  32'(oBUSY), 32'(iREQ));
        step();
        chk("rst_tmo",    32'(oTMO), 32'h0);
        chk("rst_result", oRESULT, 32'h0);
        chk("rst_fpu_n",  32'(oFPU_N), 32'h0);
        chk("rst_fpu_da", oFPU_DA, 32'h0);
        chk("rst_fpu_db", oFPU_DB, 32'h0);
        iREQ = '0;
        inRST = 1'b1;
        rr_m = 0;
        step();
    endtask

    // One complete transaction, entered and left at an IDLE-cycle negedge.
    // d: cycle after START on which the FPU strobes done (0 = never).
    task automatic op(input logic [3:0] mask, input int d, input bit drop, input bit spur);
        int          w, fin;
        bit          tmo;
        logic [2:0]  e_opc;
        logic [31:0] e_da, e_db, e_res;
        logic [3:0]  oh;
        iREQ  = mask;
        w     = pick(mask, rr_m);
        rr_m  = (w + 1) % N;
        oh    = 4'b0001 << w;
        e_opc = iOPC[3*w +: 3];
        e_da  = iDA[32*w +: 32];
        e_db  = iDB[32*w +: 32];
        tmo   = !(d >= 1 && d <= TMO);
        fin   = tmo ? TMO + 1 : d + 1;
        e_res = tmo ? 32'h0 : fpu_f(e_opc, e_da, e_db);
        step();                                   // ISSUE cycle
        chk("start",  32'(oFPU_START), 32'h1);
        chk("fpu_n",  32'(oFPU_N), 32'(e_opc));
        chk("fpu_da", oFPU_DA, e_da);
        chk("fpu_db", oFPU_DB, e_db);
        chk("issue_done", 32'(oDONE), 32'h0);
        scramble();                               // later operand changes must not leak
        iFPU_DONE   = spur;                       // done during START is ignored
        iFPU_RESULT = $urandom;
        for (int k = 1; k <= fin; k++) begin
            step();
            iFPU_DONE   = (k == d);
            iFPU_RESULT = (k == d) ? e_res : $urandom;
            if (drop && k == 2 && k < fin) iREQ[w] = 1'b0;
            if (k < fin) begin
                chk("wait_done",  32'(oDONE), 32'h0);
                chk("wait_start", 32'(oFPU_START), 32'h0);
            end else begin
                chk("done_onehot", 32'(oDONE), 32'(oh));
                chk("done_result", oRESULT, e_res);
                chk("done_tmo",    32'(oTMO), 32'(tmo));
                chk("done_busy",   32'(oBUSY), 32'(iREQ & ~oh));
            end
        end
        iFPU_DONE = 1'b0;
        iREQ = iREQ & ~oh;
        step();                                   // IDLE cycle
        chk("idle_done", 32'(oDONE), 32'h0);
        chk("idle_busy", 32'(oBUSY), 32'(iREQ));
    endtask

    initial begin
        inRST = 1'b0;
        iREQ = '0;
        iFPU_DONE = 1'b0;
        iFPU_RESULT = '0;
        scramble();
        step();
        do_reset();

        // single op, known operands, done 5 cycles after START
        iOPC[2:0]  = 3'd2;
        iDA[31:0]  = 32'h3F80_0000;
        iDB[31:0]  = 32'h4000_0000;
        op(4'b0001, 5, 1'b0, 1'b0);

        // two contenders from reset: 0,2,0,2
        do_reset();
        for (int i = 0; i < 4; i++) op(4'b0101, 2 + i, 1'b0, 1'b0);

        // all four from reset: 0,1,2,3,0 with wrap
        do_reset();
        for (int i = 0; i < 5; i++) op(4'b1111, 1 + i, 1'b0, i[0]);

        // hung FPU -> watchdog
        op(4'b0100, 0, 1'b0, 1'b0);

        // reset during WAIT; late done ignored; grant restarts at thread 0
        do_reset();
        op(4'b0001, 1, 1'b0, 1'b0);               // rr now at 1
        iREQ = 4'b0010;
        step();                                   // ISSUE for thread 1
        chk("pre_rst_start", 32'(oFPU_START), 32'h1);
        step();
        step();                                   // in WAIT
        inRST = 1'b0;
        #1;
        chk("rst_wait_done",  32'(oDONE), 32'h0);
        chk("rst_wait_start", 32'(oFPU_START), 32'h0);
        chk("rst_wait_busy",  32'(oBUSY), 32'(iREQ));
        step();
        inRST = 1'b1;
        iFPU_DONE = 1'b1;
        iFPU_RESULT = 32'hDEAD_BEEF;
        iREQ = '0;
        rr_m = 0;
        step();
        iFPU_DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_done",  32'(oDONE), 32'h0);
            chk("post_rst_start", 32'(oFPU_START), 32'h0);
        end
        op(4'b1111, 3, 1'b0, 1'b0);               // expects thread 0

        // requester drops mid-op: DONE still pulses for it
        op(4'b1010, 6, 1'b1, 1'b0);
        op(4'b1001, 2, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            scramble();
            op(4'($urandom_range(1, 15)), $urandom_range(0, TMO + 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
